// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the cache.
//   lc3b_word       : 16-bit CPU word
//   lc3b_mem_wmask  : CPU byte write mask (bit0 low byte, bit1 high byte)
//   lc3b_line       : 128-bit cache line, word k in bits [16k+15:16k]
//   lc3b_c_tag / lc3b_c_index / lc3b_c_offset : address fields for the
//                     default 8-set geometry
// Helpers select a word from a line and merge masked bytes into one.
package lc3b_types;

  localparam int C_NUM_SETS = 8;
  localparam int C_IDX_W    = $clog2(C_NUM_SETS);

  typedef logic [15:0]          lc3b_word;
  typedef logic [1:0]           lc3b_mem_wmask;
  typedef logic [127:0]         lc3b_line;
  typedef logic [11-C_IDX_W:0]  lc3b_c_tag;
  typedef logic [C_IDX_W-1:0]   lc3b_c_index;
  typedef logic [3:0]           lc3b_c_offset;

  function automatic lc3b_word line_word(input lc3b_line line, input logic [2:0] w);
    return line[{w, 4'h0} +: 16];
  endfunction

  function automatic lc3b_line merge_word(input lc3b_line      line,
                                          input logic [2:0]    w,
                                          input lc3b_word      wdata,
                                          input lc3b_mem_wmask mask);
    lc3b_line r;
    r = line;
    if (mask[0]) r[{w, 4'h0} +: 8] = wdata[7:0];
    if (mask[1]) r[{w, 4'h8} +: 8] = wdata[15:8];
    return r;
  endfunction

endpackage

// File: rtl/cache_control.sv
// Three-state controller for the direct-mapped write-back cache.
//   clk, reset      : clock, synchronous active-high reset
//   mem_read/write  : CPU request (write wins when both are set)
//   hit, dirty      : tag compare result and victim-dirty for the indexed set
//   pmem_resp       : physical transfer complete
//   mem_resp        : CPU request complete (COMPARE only)
//   pmem_read/write : line fill / write-back request
//   addr_sel_victim : 1 = pmem address uses the stored (victim) tag
//   load_write      : merge CPU write into the line and set dirty
//   load_fill       : install the fill line, tag, valid, clear dirty
//   clear_dirty     : write-back finished
//
// state     | meaning
// COMPARE   | tag check; hits respond here, misses leave
// WRITEBACK | dirty victim line sent to physical memory
// ALLOCATE  | requested line fetched from physical memory
module cache_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  input  logic hit,
  input  logic dirty,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic addr_sel_victim,
  output logic load_write,
  output logic load_fill,
  output logic clear_dirty
);

  localparam logic [1:0] S_COMPARE   = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       req;

  assign req = mem_read | mem_write;

  always_comb begin
    state_next      = state;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    addr_sel_victim = 1'b0;
    load_write      = 1'b0;
    load_fill       = 1'b0;
    clear_dirty     = 1'b0;
    case (state)
      S_COMPARE: begin
        if (req) begin
          if (hit) begin
            mem_resp   = 1'b1;
            load_write = mem_write;
          end else if (dirty) begin
            state_next = S_WRITEBACK;
          end else begin
            state_next = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write      = 1'b1;
        addr_sel_victim = 1'b1;
        if (pmem_resp) begin
          clear_dirty = 1'b1;
          state_next  = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        // The fill completes even if the CPU has dropped its request.
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_fill  = 1'b1;
          state_next = S_COMPARE;
        end
      end
      default: state_next = S_COMPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_COMPARE;
    else       state <= state_next;
  end

endmodule

// File: rtl/lc3b_cache.sv
// Direct-mapped, write-back, write-allocate cache between the LC-3b CPU
// memory port and a 128-bit line-wide physical memory.
//   clk, reset       : clock, synchronous active-high reset
//   mem_address      : CPU byte address (bit 0 ignored for word select)
//   mem_read/write   : CPU request, held until mem_resp
//   mem_byte_enable  : byte mask for writes
//   mem_wdata        : CPU write data
//   mem_rdata        : selected word on a hit, else 0
//   mem_resp         : request complete
//   pmem_address     : line-aligned physical address (0 when idle)
//   pmem_read/write  : fill / write-back request
//   pmem_wdata       : victim line during write-back (0 otherwise)
//   pmem_rdata       : fill line
//   pmem_resp        : physical transfer complete
module lc3b_cache
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_byte_enable,
  input  logic [15:0]   mem_wdata,
  output logic [15:0]   mem_rdata,
  output logic          mem_resp,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] idx;
  lc3b_c_offset     offset;
  logic [2:0]       word;
  logic             unused_byte_bit;

  assign req_tag         = mem_address[15:4+IDX_W];
  assign idx             = mem_address[3+IDX_W:4];
  assign offset          = mem_address[3:0];
  assign word            = offset[3:1];
  assign unused_byte_bit = offset[0];

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  lc3b_line            data_q [NUM_SETS];

  logic hit;
  logic victim_dirty;
  logic addr_sel_victim;
  logic load_write;
  logic load_fill;
  logic clear_dirty;

  assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  cache_control u_ctrl (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .hit             (hit),
    .dirty           (victim_dirty),
    .pmem_resp       (pmem_resp),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .addr_sel_victim (addr_sel_victim),
    .load_write      (load_write),
    .load_fill       (load_fill),
    .clear_dirty     (clear_dirty)
  );

  logic [TAG_W-1:0] pmem_tag;

  assign pmem_tag     = addr_sel_victim ? tag_q[idx] : req_tag;
  assign pmem_address = (pmem_read || pmem_write) ? {pmem_tag, idx, 4'h0} : 16'h0000;
  assign pmem_wdata   = pmem_write ? data_q[idx] : '0;
  assign mem_rdata    = mem_resp ? line_word(data_q[idx], word) : 16'h0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (load_write)  dirty_q[idx] <= 1'b1;
      if (clear_dirty) dirty_q[idx] <= 1'b0;
      if (load_fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tag and data are not reset; a pmem_resp landing in the reset cycle
  // must not install a line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load_write)
        data_q[idx] <= merge_word(data_q[idx], word, mem_wdata, mem_byte_enable);
      if (load_fill) begin
        data_q[idx] <= pmem_rdata;
        tag_q[idx]  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_lc3b_cache.sv
module tb_lc3b_cache;
  import lc3b_types::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  lc3b_cache #(.NUM_SETS(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [1:0]  mask;
    logic [15:0] wdata;
    logic        chk_data;
    logic [15:0] exp;
    int          cyc;
    logic        wb;
    logic [15:0] wb_addr;
    logic        fill;
  } vec_t;

  typedef struct {
    logic        w;
    logic [15:0] addr;
    lc3b_line    data;
  } ptx_t;

  typedef struct {
    logic        chk_data;
    logic [15:0] data;
    int          cyc;
  } rsp_t;

  ptx_t pexp[$];
  rsp_t rq[$];
  vec_t vecs[$];

  lc3b_line mem  [logic [15:0]];
  lc3b_line gold [logic [15:0]];

  int   fill_lat = 3;
  int   wb_lat   = 2;
  bit   stray    = 1'b0;
  int   pcnt     = 0;
  ptx_t pe;

  function automatic logic [15:0] pat_word(input logic [15:0] la, input int k);
    return la ^ 16'hA5A0 ^ 16'(k);
  endfunction

  function automatic lc3b_line pat_line(input logic [15:0] la);
    lc3b_line r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = pat_word(la, k);
    return r;
  endfunction

  function automatic lc3b_line mem_line(input logic [15:0] la);
    if (mem.exists(la)) return mem[la];
    return pat_line(la);
  endfunction

  function automatic lc3b_line gold_line(input logic [15:0] la);
    if (gold.exists(la)) return gold[la];
    return pat_line(la);
  endfunction

  function automatic vec_t mk(input logic [15:0] addr, input logic rd, input logic wr,
                              input logic [1:0] mask, input logic [15:0] wdata,
                              input logic chk_data, input logic [15:0] exp, input int cyc,
                              input logic wb, input logic [15:0] wb_addr, input logic fill);
    vec_t v;
    v.addr = addr; v.rd = rd; v.wr = wr; v.mask = mask; v.wdata = wdata;
    v.chk_data = chk_data; v.exp = exp; v.cyc = cyc;
    v.wb = wb; v.wb_addr = wb_addr; v.fill = fill;
    return v;
  endfunction

  // Physical memory: answers after a fixed latency and scoreboards each transfer.
  always @(negedge clk) begin
    if (reset) begin
      pmem_resp = 1'b0;
      pcnt      = 0;
    end else begin
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        pcnt      = 0;
      end
      if (stray) begin
        pmem_resp = 1'b1;
        stray     = 1'b0;
      end else if (pmem_read || pmem_write) begin
        chk("pmem_rd_wr_exclusive", 128'(pmem_read & pmem_write), 128'(0));
        pcnt++;
        if (pcnt == (pmem_write ? wb_lat : fill_lat)) begin
          pmem_resp = 1'b1;
          if (pexp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pmem_unexpected: got transfer w=%0d addr %h expected none",
                     pmem_write, pmem_address);
          end else begin
            pe = pexp.pop_front();
            chk("pmem_dir", 128'(pmem_write), 128'(pe.w));
            chk("pmem_addr", 128'(pmem_address), 128'(pe.addr));
            if (pe.w) chk("pmem_wdata", pmem_wdata, pe.data);
          end
          if (pmem_write) mem[pmem_address] = pmem_wdata;
          else            pmem_rdata = mem_line(pmem_address);
        end
      end else begin
        pcnt = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input int n);
    ptx_t        p;
    rsp_t        r;
    int          cyc;
    bit          got;
    lc3b_line    g;
    logic [15:0] la;
    int          w;
    la = {v.addr[15:4], 4'h0};
    if (v.wb) begin
      p.w = 1'b1; p.addr = v.wb_addr; p.data = gold_line(v.wb_addr);
      pexp.push_back(p);
    end
    if (v.fill) begin
      p.w = 1'b0; p.addr = la; p.data = '0;
      pexp.push_back(p);
    end
    r.chk_data = v.chk_data; r.data = v.exp; r.cyc = v.cyc;
    rq.push_back(r);
    if (v.wr) begin
      g = gold_line(la);
      w = int'(v.addr[3:1]);
      if (v.mask[0]) g[w*16 +: 8]     = v.wdata[7:0];
      if (v.mask[1]) g[w*16 + 8 +: 8] = v.wdata[15:8];
      gold[la] = g;
    end
    @(posedge clk); #1;
    mem_address = v.addr; mem_read = v.rd; mem_write = v.wr;
    mem_byte_enable = v.mask; mem_wdata = v.wdata;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_resp) got = 1'b1;
    end
    r = rq.pop_front();
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL v%0d_timeout: got no mem_resp in %0d cycles expected %0d", n, cyc, r.cyc);
    end else begin
      if (r.chk_data) chk($sformatf("v%0d_rdata", n), 128'(mem_rdata), 128'(r.data));
      chk($sformatf("v%0d_cycles", n), 128'(cyc), 128'(r.cyc));
    end
    chk($sformatf("v%0d_pmem_pending", n), 128'(pexp.size()), 128'(0));
    pexp.delete();
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_mem_resp"},   128'(mem_resp), 128'(0));
    chk({tag, "_mem_rdata"},  128'(mem_rdata), 128'(0));
    chk({tag, "_pmem_read"},  128'(pmem_read), 128'(0));
    chk({tag, "_pmem_write"}, 128'(pmem_write), 128'(0));
    chk({tag, "_pmem_addr"},  128'(pmem_address), 128'(0));
    chk({tag, "_pmem_wdata"}, pmem_wdata, 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lc3b_line    l1230;
    logic [15:0] t;
    bit          seen;

    for (int k = 0; k < 8; k++) l1230[k*16 +: 16] = 16'(k);
    mem[16'h1230]  = l1230;
    gold[16'h1230] = l1230;
    t = pat_word(16'h0040, 4);

    vecs.push_back(mk(16'h1236, 1, 0, 2'b00, 16'h0000, 1, 16'h0003, 5, 0, 16'h0, 1));
    vecs.push_back(mk(16'h1230, 1, 0, 2'b00, 16'h0000, 1, 16'h0000, 1, 0, 16'h0, 0));
    vecs.push_back(mk(16'h1233, 0, 1, 2'b10, 16'hAB00, 0, 16'h0000, 1, 0, 16'h0, 0));
    vecs.push_back(mk(16'h1232, 1, 0, 2'b00, 16'h0000, 1, 16'hAB01, 1, 0, 16'h0, 0));
    vecs.push_back(mk(16'h5230, 1, 0, 2'b00, 16'h0000, 1, pat_word(16'h5230, 0), 7, 1, 16'h1230, 1));
    vecs.push_back(mk(16'h1232, 1, 0, 2'b00, 16'h0000, 1, 16'hAB01, 5, 0, 16'h0, 1));
    vecs.push_back(mk(16'h1236, 0, 1, 2'b00, 16'hFFFF, 0, 16'h0000, 1, 0, 16'h0, 0));
    vecs.push_back(mk(16'h1236, 1, 0, 2'b00, 16'h0000, 1, 16'h0003, 1, 0, 16'h0, 0));
    vecs.push_back(mk(16'h9230, 1, 0, 2'b00, 16'h0000, 1, pat_word(16'h9230, 0), 7, 1, 16'h1230, 1));
    vecs.push_back(mk(16'h0048, 1, 0, 2'b00, 16'h0000, 1, pat_word(16'h0040, 4), 5, 0, 16'h0, 1));
    vecs.push_back(mk(16'h004A, 1, 1, 2'b11, 16'hBEEF, 0, 16'h0000, 1, 0, 16'h0, 0));
    vecs.push_back(mk(16'h004A, 1, 0, 2'b00, 16'h0000, 1, 16'hBEEF, 1, 0, 16'h0, 0));
    vecs.push_back(mk(16'h0049, 0, 1, 2'b01, 16'h1299, 0, 16'h0000, 1, 0, 16'h0, 0));
    vecs.push_back(mk(16'h0048, 1, 0, 2'b00, 16'h0000, 1, {t[15:8], 8'h99}, 1, 0, 16'h0, 0));
    vecs.push_back(mk(16'h8040, 1, 0, 2'b00, 16'h0000, 1, pat_word(16'h8040, 0), 7, 1, 16'h0040, 1));
    vecs.push_back(mk(16'h004A, 1, 0, 2'b00, 16'h0000, 1, 16'hBEEF, 5, 0, 16'h0, 1));
    vecs.push_back(mk(16'h0048, 0, 1, 2'b11, 16'h7777, 0, 16'h0000, 1, 0, 16'h0, 0));

    reset = 1'b1; mem_address = 16'h0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_wdata = 16'h0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    idle_check("reset_idle");

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset while a fill is outstanding; the dirty 0x0040 line is dropped.
    @(posedge clk); #1;
    fill_lat = 20;
    mem_address = 16'h3230; mem_read = 1'b1; mem_write = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
    end
    chk("rst_alloc_seen", 128'(seen), 128'(1));
    chk("rst_alloc_addr", 128'(pmem_address), 128'(16'h3230));
    @(posedge clk); #1;
    reset = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0; stray = 1'b1;
    @(negedge clk);
    chk("rst_next_pmem_read",  128'(pmem_read), 128'(0));
    chk("rst_next_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_next_mem_resp",   128'(mem_resp), 128'(0));
    @(negedge clk);
    chk("rst_stray_pmem_read", 128'(pmem_read), 128'(0));
    gold = mem;
    fill_lat = 3;
    pexp.delete();

    run_vec(mk(16'h0048, 1, 0, 2'b00, 16'h0000, 1, {t[15:8], 8'h99}, 5, 0, 16'h0, 1), 100);
    run_vec(mk(16'h9230, 1, 0, 2'b00, 16'h0000, 1, pat_word(16'h9230, 0), 5, 0, 16'h0, 1), 101);

    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    idle_check("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
